// File: rtl/shared_resource_arbiter.sv
// Fixed-priority, lock-until-release arbiter for one shared single-ported resource.
// Optional forced revoke after MAX_HOLD grant cycles when built with ARB_TIMEOUT_EN.
module shared_resource_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_d;
  logic [IW-1:0]   id_d;
  logic            busy_d;
  logic [N-1:0]    cand;
  logic [N-1:0]    sel_hot;
  logic [IW-1:0]   sel_id;
  logic            sel_found;
  logic            release_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  skip_q, skip_d;
  logic          timeout_d;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD >= 1);
`endif

  // Candidate set: a just-revoked index steps aside while anyone else is asking.
  always_comb begin
    cand = req;
`ifdef ARB_TIMEOUT_EN
    if ((req & ~skip_q) != '0) begin
      cand = req & ~skip_q;
    end
`endif
  end

  // Lowest set candidate index wins.
  always_comb begin
    sel_hot   = '0;
    sel_id    = '0;
    sel_found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (cand[i] && !sel_found) begin
        sel_found  = 1'b1;
        sel_hot[i] = 1'b1;
        sel_id     = IW'(i);
      end
    end
  end

  assign release_c = ((grant & done) != '0) || ((grant & req) == '0);

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    id_d    = '0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    skip_d    = skip_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = OWNED;
          grant_d = sel_hot;
          id_d    = sel_id;
`ifdef ARB_TIMEOUT_EN
          hold_d = '0;
          skip_d = '0;
`endif
        end
      end
      OWNED: begin
        if (release_c) begin
          state_d = IDLE;
        end else begin
          grant_d = grant;
          id_d    = grant_id;
`ifdef ARB_TIMEOUT_EN
          // Last allowed cycle with no release: revoke and remember who it was.
          if (hold_q == HW'(MAX_HOLD - 1)) begin
            state_d   = IDLE;
            grant_d   = '0;
            id_d      = '0;
            timeout_d = 1'b1;
            skip_d    = grant;
          end else begin
            hold_d = hold_q + HW'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (grant_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      grant_id <= id_d;
      busy     <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      skip_q  <= '0;
      timeout <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      skip_q  <= skip_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Bench for shared_resource_arbiter: vector table, directed corner cases, random vs model.
module tb_shared_resource_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout;

  int checks = 0;
  int passed = 0;

  // Reference model state: owner index or -1, cycles held so far, skipped index or -1.
  int m_owner = -1;
  int m_hold  = 0;
  int m_skip  = -1;
  bit m_to    = 1'b0;

  shared_resource_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r;
    logic [N-1:0] q;
    logic [N-1:0] d;
    logic [N-1:0] g;
    int           id;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
    int pick;
    m_to = 1'b0;
    if (r) begin
      m_owner = -1; m_hold = 0; m_skip = -1;
    end else if (m_owner < 0) begin
      pick = -1;
      for (int i = 0; i < int'(N); i++) if (q[i] && i != m_skip && pick < 0) pick = i;
      for (int i = 0; i < int'(N); i++) if (q[i] && pick < 0) pick = i;
      if (pick >= 0) begin
        m_owner = pick; m_hold = 1; m_skip = -1;
      end
    end else if (d[m_owner] || !q[m_owner]) begin
      m_owner = -1;
    end else if (TO_EN && m_hold == int'(MAX_HOLD)) begin
      m_skip = m_owner; m_owner = -1; m_to = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic tick(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
    rst = r; req = q; done = d;
    model_step(r, q, d);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] g, input int id,
                            input bit to);
    chk({name, ".grant"}, int'(grant), int'(g));
    chk({name, ".grant_id"}, int'(grant_id), id);
    chk({name, ".busy"}, int'(busy), int'(g != '0));
    chk({name, ".timeout"}, int'(timeout), int'(to));
  endtask

  initial begin
    vec_t tbl[21];
    logic [N-1:0] rq;
    logic [N-1:0] dn;
    logic         rr;
    string        nm;

    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[1]  = '{1'b0, 4'b0110, 4'b0000, 4'b0010, 1};
    tbl[2]  = '{1'b0, 4'b0110, 4'b0000, 4'b0010, 1};
    tbl[3]  = '{1'b0, 4'b0110, 4'b0010, 4'b0000, 0};
    tbl[4]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2};
    tbl[5]  = '{1'b0, 4'b0101, 4'b0000, 4'b0100, 2};
    tbl[6]  = '{1'b0, 4'b0101, 4'b0100, 4'b0000, 0};
    tbl[7]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 0};
    tbl[8]  = '{1'b0, 4'b0001, 4'b1010, 4'b0001, 0};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[10] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 0};
    tbl[11] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 0};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 0};
    tbl[13] = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 0};
    tbl[14] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 0};
    tbl[15] = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 0};
    tbl[16] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 3};
    tbl[17] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 3};
    tbl[18] = '{1'b1, 4'b1000, 4'b0000, 4'b0000, 0};
    tbl[19] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 3};
    tbl[20] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0};

    rst = 1'b1; req = '0; done = '0;
    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].r, tbl[i].q, tbl[i].d);
      nm = $sformatf("vec%0d", i);
      expect_out(nm, tbl[i].g, tbl[i].id, 1'b0);
    end

`ifdef ARB_TIMEOUT_EN
    tick(1'b1, 4'b0000, 4'b0000);
    for (int c = 1; c <= 4; c++) begin
      tick(1'b0, 4'b0011, 4'b0000);
      expect_out($sformatf("hold_c%0d", c), 4'b0001, 0, 1'b0);
    end
    tick(1'b0, 4'b0011, 4'b0000);
    expect_out("revoke", 4'b0000, 0, 1'b1);
    tick(1'b0, 4'b0011, 4'b0000);
    expect_out("after_revoke", 4'b0010, 1, 1'b0);
    tick(1'b0, 4'b0000, 4'b0000);
    expect_out("drop1", 4'b0000, 0, 1'b0);
    for (int c = 1; c <= 3; c++) tick(1'b0, 4'b0011, 4'b0000);
    expect_out("regrant_c3", 4'b0001, 0, 1'b0);
    tick(1'b0, 4'b0011, 4'b0000);
    expect_out("regrant_c4", 4'b0001, 0, 1'b0);
    tick(1'b0, 4'b0011, 4'b0001);
    expect_out("done_on_last", 4'b0000, 0, 1'b0);
    tick(1'b0, 4'b0011, 4'b0000);
    expect_out("no_skip", 4'b0001, 0, 1'b0);
`else
    tick(1'b1, 4'b0000, 4'b0000);
    tick(1'b0, 4'b0110, 4'b0000);
    expect_out("hold_first", 4'b0010, 1, 1'b0);
    for (int c = 0; c < 100; c++) tick(1'b0, 4'b0110, 4'b0000);
    expect_out("hold_100", 4'b0010, 1, 1'b0);
`endif

    // Random traffic against the reference model.
    tick(1'b1, 4'b0000, 4'b0000);
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) rq = N'($urandom);
      for (int b = 0; b < int'(N); b++) dn[b] = ($urandom_range(7) == 0);
      rr = ($urandom_range(99) == 0);
      tick(rr, rq, dn);
      expect_out($sformatf("rand%0d", c),
                 (m_owner < 0) ? N'(0) : N'(1) << m_owner,
                 (m_owner < 0) ? 0 : m_owner, m_to);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/shared_resource_arbiter.md
# shared_resource_arbiter

- Sequential fixed-priority arbiter that shares one single-ported resource among N requesters.
- Index 0 has the highest priority.
- A grant is registered one-hot and locked to its owner until that owner releases it, so a multi-cycle transaction is never preempted.
- Sits between requesting masters and the shared resource; `grant_id` drives the resource's input mux select.

## Interface
- `N`, default 4: number of requesters, N ≥ 2.
- `MAX_HOLD`, default 16: maximum grant-high cycles before forced revoke; used only with the timeout feature, MAX_HOLD ≥ 1.
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  request vector, level; held by a requester until released.
- `done`  in  N  release strobe per requester; meaningful only for the current owner.
- `grant`  out  N  registered one-hot grant, all-zero when idle.
- `grant_id`  out  $clog2(N)  binary index of the owner; 0 when idle.
- `busy`  out  1  high while any grant is high; equals |grant.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked.
- One clock, `clk`; reset `rst` is synchronous and active-high.

## Operation
- Two-state FSM: IDLE and OWNED.
- IDLE:
  - If `req` is non-zero, select the lowest set index, excluding a masked index (see Configuration).
  - Register the one-hot `grant` and `grant_id`, then go to OWNED.
  - If `req` is zero, stay in IDLE with outputs at zero.
- OWNED:
  - Release condition: `done[owner]`=1 or `req[owner]`=0 sampled on the same edge.
  - On release, clear `grant`, `grant_id` and `busy` on that edge and return to IDLE.
- Rules while OWNED:
  - Requests from other indices are ignored, including higher-priority ones; there is no preemption.
  - `done` bits of non-owners are ignored.
  - Multiple `done` bits set: only the owner's bit is evaluated.
- Turnaround: after any release or revoke there is at least one IDLE cycle with `grant`=0 before the next grant. This applies even to the same requester.
- Reset at any point, including mid-transaction: on the next edge `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0, FSM=IDLE, hold counter=0, skip mask cleared.
- `grant` is never multi-hot. `grant_id` is always consistent with `grant` in the same cycle.

## Timing
- Reset values: `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0.
- Grant latency: `req` sampled on edge k while IDLE gives `grant` high in the cycle after edge k (one cycle).
- Release latency: release sampled on edge m gives `grant` low in the cycle after edge m.
- Minimum grant length is 1 cycle; `done` may be high in the first grant cycle.
- Back-to-back service of two requesters: grant A, ≥1 idle cycle, then grant B. With both held continuously, the pattern is A for L cycles, 1 idle cycle, B.
- `timeout` is high only in the same cycle that `grant` first reads 0 after a revoke.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter clears on grant and counts grant-high cycles.
  - If the grant has been high MAX_HOLD cycles and the MAX_HOLD-th cycle samples no release, the grant is revoked on that edge and `timeout` pulses for one cycle. The FSM returns to IDLE.
  - A release sampled on the MAX_HOLD-th cycle wins: normal release, no `timeout`.
  - The revoked index is set in a one-entry skip mask. The next IDLE arbitration excludes it if any other `req` bit is set.
  - The mask clears after that arbitration completes, or when the masked index is the only requester, in which case it is granted.
- Undefined:
  - No counter and no mask are implemented; `timeout` is tied to 0.
  - A grant is held indefinitely until released.

## Test plan
- Reset then `req`=4'b0110 held, `done` low:
  - Next cycle `grant`=4'b0010, `grant_id`=1, `busy`=1.
  - With the macro off, it is still 4'b0010 after 100 cycles.
- Owner 2 granted, then `req[0]` rises:
  - `grant` stays 4'b0100.
  - `done[2]` pulse gives `grant`=0 for one cycle, then `grant`=4'b0001.
- `req`=4'b1111 continuously with the owner pulsing `done` on its 3rd grant cycle:
  - Grant sequence is 0001, 0001, 0001, 0000, then 0001 again (fixed priority).
- `done`=4'b1010 while owner is 0:
  - No release.
  - Dropping `req[0]` releases on the next edge.
- `rst` asserted on the 2nd grant cycle of owner 3:
  - Next cycle all outputs are 0.
  - After `rst` drops with `req`=4'b1000, `grant`=4'b1000 one cycle later.
- With `ARB_TIMEOUT_EN`, MAX_HOLD=4, `req`=4'b0011 held, no `done`:
  - `grant`=0001 for 4 cycles, then `grant`=0 with `timeout`=1, then `grant`=0010.
  - Then repeat with `done[0]` on the 4th cycle: no `timeout`.
